decoder: RTL

DECODER -- requirements
Module: decoder

---
 rtl/decoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/decoder.sv
// Oversampling serial frame receiver: start, 8 data bits, odd parity, stop.
// Samples the synchronized line at mid-bit on clk_en ticks and reports each frame with a q_rdy pulse.
module decoder #(
    parameter int OVERSAMPLE = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clk_en,
    input  logic       d,
    output logic [7:0] q,
    output logic       q_rdy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          ds;
    logic [CW-1:0] smp_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic          armed;

    // Sync flops reset to 1 so the idle-high line is not mistaken for a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], d};
        end
    end

    assign ds   = sync[1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            smp_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            armed      <= 1'b0;
            q          <= 8'h00;
            q_rdy      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            q_rdy <= 1'b0;
            if (clk_en) begin
                unique case (state)
                    // Arming only in IDLE forces a high tick after every frame, even one ending low.
                    IDLE: begin
                        if (ds) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            armed   <= 1'b0;
                            smp_cnt <= '0;
                            state   <= START;
                        end
                    end
                    START: begin
                        if (smp_cnt == MID_CNT) begin
                            smp_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= ds ? IDLE : DATA;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (smp_cnt == LAST_CNT) begin
                            smp_cnt <= '0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (MSB_FIRST) shift <= {shift[6:0], ds};
                            else           shift <= {ds, shift[7:1]};
                            if (bit_cnt == 3'd7) state <= PARITY;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (smp_cnt == LAST_CNT) begin
                            smp_cnt <= '0;
                            par_bit <= ds;
                            state   <= STOP;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (smp_cnt == LAST_CNT) begin
                            smp_cnt    <= '0;
                            q          <= shift;
                            parity_err <= ~(^shift ^ par_bit);
                            frame_err  <= ~ds;
                            q_rdy      <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
